fifo_burst_arb: RTL and testbench

- Round-robin write arbiter that shares a single 16-bit FIFO write port between NUM_REQ producers.
- Grants fixed-length bursts only when the FIFO reports enough free space. Sequences per-beat pops from the winner and drives registered wr_en/din into the FIFO.
- Sits between producer blocks and the FIFO IP write side, in the same clock domain.

---
 rtl/fifo_burst_arb.sv | 184 ++++++++++++++++++
 tb/tb_fifo_burst_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_arb.sv
// -----------------------------------------------------------------------------
// fifo_burst_arb
//   Round-robin write arbiter that shares one FIFO write port between NUM_REQ
//   producers. A producer is granted a fixed-length burst of BURST_LEN beats
//   only when the FIFO has at least BURST_LEN + MARGIN free words. During the
//   burst the arbiter pops words from the owner (req_ack) and writes them into
//   the FIFO one cycle later through registered wr_en/din.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req                   per-requester "word available"
//   req_data              requester data, slice i = [i*DATA_W +: DATA_W]
//   req_ack               pop strobe to the current owner (combinational)
//   grant, cur_id         registered one-hot owner / owner index
//   fifo_full             FIFO full flag
//   fifo_wr_data_count    FIFO write-side occupancy
//   fifo_wr_en, fifo_din  registered FIFO write port
//   busy                  high while a burst is running or closing
//   burst_done            one-cycle pulse after the last beat is written
// -----------------------------------------------------------------------------
module fifo_burst_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 9,
    parameter int DEPTH     = 256,
    parameter int BURST_LEN = 16,
    parameter int MARGIN    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic [2:0]                cur_id,
    input  logic                      fifo_full,
    input  logic [CNT_W-1:0]          fifo_wr_data_count,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      busy,
    output logic                      burst_done
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W:0] DEPTH_X = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W:0] NEED_X  = (CNT_W+1)'(BURST_LEN + MARGIN);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [2:0]          cur_id_q, cur_id_d;
    logic [2:0]          rr_q, rr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   slice [NUM_REQ];
    logic [DATA_W-1:0]   sel_data;
    logic                own_req;
    logic [NUM_REQ-1:0]  ack;
    logic [CNT_W:0]      cnt_ext;
    logic [CNT_W:0]      free_words;
    logic                space_ok;
    logic                win_found;
    logic [2:0]          win_id;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign slice[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // An occupancy above DEPTH (should never happen) is treated as a full FIFO.
    assign cnt_ext    = {1'b0, fifo_wr_data_count};
    assign free_words = (cnt_ext > DEPTH_X) ? '0 : (DEPTH_X - cnt_ext);
    assign space_ok   = !fifo_full && (free_words >= NEED_X);

    // Round-robin search: offsets are scanned from the largest down so that
    // the requester closest to the pointer is the one left standing.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (((int'(rr_q) + k) % NUM_REQ == j) && req[j]) begin
                    win_found = 1'b1;
                    win_id    = 3'(j);
                end
            end
        end
    end

    // Owner's request bit and data word.
    always_comb begin
        own_req  = 1'b0;
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (cur_id_q == 3'(j)) begin
                own_req  = req[j];
                sel_data = slice[j];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cur_id_d = cur_id_q;
        rr_d     = rr_q;
        beat_d   = beat_q;
        wr_en_d  = 1'b0;
        din_d    = din_q;
        done_d   = 1'b0;
        ack      = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found && space_ok) begin
                    state_d  = S_BURST;
                    cur_id_d = win_id;
                    beat_d   = '0;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        grant_d[j] = (win_id == 3'(j));
                    end
                end
            end
            S_BURST: begin
                // A beat stalls (no pop, grant held) while the owner has no
                // word or the FIFO is full.
                if (own_req && !fifo_full) begin
                    for (int j = 0; j < NUM_REQ; j++) begin
                        ack[j] = (cur_id_q == 3'(j));
                    end
                    wr_en_d = 1'b1;
                    din_d   = sel_data;
                    beat_d  = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Last owner becomes lowest priority for the next search.
                done_d  = 1'b1;
                grant_d = '0;
                rr_d    = (cur_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : (cur_id_q + 3'd1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            cur_id_q <= '0;
            rr_q     <= '0;
            beat_q   <= '0;
            wr_en_q  <= 1'b0;
            din_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cur_id_q <= cur_id_d;
            rr_q     <= rr_d;
            beat_q   <= beat_d;
            wr_en_q  <= wr_en_d;
            din_q    <= din_d;
            done_q   <= done_d;
        end
    end

    assign req_ack    = ack;
    assign grant      = grant_q;
    assign cur_id     = cur_id_q;
    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;
    assign busy       = (state_q != S_IDLE);
    assign burst_done = done_q;

endmodule

// File: tb/tb_fifo_burst_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_arb
//   Randomised and directed stimulus for fifo_burst_arb, checked every cycle
//   against a behavioural model of the arbitration rules. Producers present
//   words {id, sequence number} and advance on each predicted pop.
// -----------------------------------------------------------------------------
module tb_fifo_burst_arb;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 16;
    localparam int CNT_W     = 9;
    localparam int DEPTH     = 256;
    localparam int BURST_LEN = 16;
    localparam int MARGIN    = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        grant;
    logic [2:0]                cur_id;
    logic                      fifo_full = 1'b0;
    logic [CNT_W-1:0]          fifo_wr_data_count = '0;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_din;
    logic                      busy;
    logic                      burst_done;

    always #5 clk = ~clk;

    fifo_burst_arb #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W),
        .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .MARGIN(MARGIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .req_ack(req_ack), .grant(grant), .cur_id(cur_id),
        .fifo_full(fifo_full), .fifo_wr_data_count(fifo_wr_data_count),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .busy(busy), .burst_done(burst_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase 0 = waiting, 1 = moving beats, 2 = closing cycle.
    int          m_ph    = 0;
    int          m_beats = 0;
    logic [1:0]  m_cur   = '0;
    logic [1:0]  m_ptr   = '0;
    bit          m_wr    = 1'b0;
    bit          m_done  = 1'b0;
    logic [15:0] m_din   = '0;

    int prod_cnt [NUM_REQ];
    int burst_writes = 0;
    int burst_no     = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] word(input logic [1:0] i);
        int c;
        c = prod_cnt[i];
        return {2'b00, i, c[11:0]};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_beats = 0; m_cur = '0; m_ptr = '0;
        m_wr = 1'b0; m_done = 1'b0; m_din = '0;
        burst_writes = 0;
    endtask

    // Compare this cycle's outputs against the model, then apply the clock edge.
    task automatic model_step();
        logic [NUM_REQ-1:0] e_grant;
        logic [NUM_REQ-1:0] e_ack;
        logic [1:0]         idx;
        int                 free_w;
        e_grant = (m_ph != 0) ? (NUM_REQ'(1) << m_cur) : '0;
        e_ack   = '0;
        if (m_ph == 1 && req[m_cur] && !fifo_full) e_ack = NUM_REQ'(1) << m_cur;

        check_val("grant",      32'(grant),      32'(e_grant));
        check_val("cur_id",     32'(cur_id),     32'(m_cur));
        check_val("busy",       32'(busy),       32'(m_ph != 0));
        check_val("req_ack",    32'(req_ack),    32'(e_ack));
        check_val("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr));
        check_val("fifo_din",   32'(fifo_din),   32'(m_din));
        check_val("burst_done", 32'(burst_done), 32'(m_done));

        if (fifo_wr_en) burst_writes++;
        if (m_done) begin
            check_val("burst_writes", 32'(burst_writes), 32'(BURST_LEN));
            $display("burst %0d owner %0d writes %0d", burst_no, m_cur, burst_writes);
            burst_writes = 0;
            burst_no++;
        end

        m_done = (m_ph == 2);
        m_wr   = (e_ack != '0);
        if (m_wr) begin
            m_din = word(m_cur);
            prod_cnt[m_cur]++;
        end
        case (m_ph)
            0: begin
                free_w = (int'(fifo_wr_data_count) > DEPTH) ? 0 : DEPTH - int'(fifo_wr_data_count);
                if (req != '0 && !fifo_full && free_w >= BURST_LEN + MARGIN) begin
                    for (int k = NUM_REQ - 1; k >= 0; k--) begin
                        idx = m_ptr + 2'(k);
                        if (req[idx]) m_cur = idx;
                    end
                    m_beats = 0;
                    m_ph    = 1;
                end
            end
            1: begin
                if (m_wr) begin
                    m_beats++;
                    if (m_beats == BURST_LEN) m_ph = 2;
                end
            end
            default: begin
                m_ptr = m_cur + 2'd1;
                m_ph  = 0;
            end
        endcase
    endtask

    task automatic cyc(input logic [NUM_REQ-1:0] r, input bit f, input int cnt);
        @(posedge clk);
        #1;
        req                = r;
        fifo_full          = f;
        fifo_wr_data_count = CNT_W'(cnt);
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = word(2'(i));
        @(negedge clk);
        model_step();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check_val("rst_grant",  32'(grant),      32'd0);
        check_val("rst_cur_id", 32'(cur_id),     32'd0);
        check_val("rst_busy",   32'(busy),       32'd0);
        check_val("rst_ack",    32'(req_ack),    32'd0);
        check_val("rst_wr_en",  32'(fifo_wr_en), 32'd0);
        check_val("rst_din",    32'(fifo_din),   32'd0);
        check_val("rst_done",   32'(burst_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Let any running burst finish so the next phase starts from idle.
    task automatic drain();
        int n;
        n = 0;
        while (m_ph != 0 && n < 100) begin
            cyc('1, 1'b0, 0);
            n++;
        end
        check_val("drain_bound", 32'(m_ph), 32'd0);
    endtask

    task automatic run_until_beat(input logic [NUM_REQ-1:0] r, input int owner, input int beat, input string tag);
        int n;
        n = 0;
        while (!(m_ph == 1 && int'(m_cur) == owner && m_beats == beat) && n < 100) begin
            cyc(r, 1'b0, 0);
            n++;
        end
        check_val(tag, 32'(m_beats), 32'(beat));
    endtask

    initial begin
        int sel;
        int cnt;
        for (int i = 0; i < NUM_REQ; i++) prod_cnt[i] = 0;

        pulse_reset();

        // Single requester, empty FIFO.
        for (int i = 0; i < 40; i++) cyc(4'b0001, 1'b0, 0);
        drain();

        // All requesting: strict rotation.
        for (int i = 0; i < 90; i++) cyc(4'b1111, 1'b0, 0);
        drain();

        // Free-space threshold: 19 free is not enough, 20 is.
        for (int i = 0; i < 5; i++) cyc(4'b0001, 1'b0, 237);
        for (int i = 0; i < 20; i++) cyc(4'b0001, 1'b0, 236);
        drain();

        // Owner withdraws its request mid-burst.
        run_until_beat(4'b0100, 2, 5, "wait_beat5");
        for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0, 0);
        for (int i = 0; i < 20; i++) cyc(4'b0100, 1'b0, 0);
        drain();

        // FIFO goes full mid-burst.
        run_until_beat(4'b0001, 0, 8, "wait_beat8");
        for (int i = 0; i < 2; i++) cyc(4'b0001, 1'b1, 0);
        for (int i = 0; i < 20; i++) cyc(4'b0001, 1'b0, 0);
        drain();

        // Reset in the middle of a burst, then a fresh grant to requester 1.
        run_until_beat(4'b0001, 0, 10, "wait_beat10");
        pulse_reset();
        for (int i = 0; i < 25; i++) cyc(4'b0010, 1'b0, 0);

        // Random traffic, stalls, and occupancy including out-of-range counts.
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel <= 5)      cnt = int'($urandom_range(0, 200));
            else if (sel == 6) cnt = int'($urandom_range(230, 240));
            else               cnt = int'($urandom_range(250, 511));
            cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0), cnt);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
